// File: rtl/decode_pipe_ctrl.sv
// decode_pipe_ctrl
//
// Single-stage instruction decode register with a valid/ready handshake on
// both sides, a RAW hazard scoreboard that stalls the input, a synchronous
// flush, and two saturating statistics counters.
//
// Instruction word layout, MSB to LSB: ri | op | rd | rs | imm.
// For R-type words (ri=0) the rt register is the top REG_W bits of imm.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     instruction present on in_inst
//   in_inst      instruction word (INST_W bits)
//   in_ready     instruction accepted when in_valid is also high
//   flush        synchronous clear of the output register and scoreboard
//   out_valid    decoded fields valid
//   out_ready    downstream accepts the decoded fields
//   alu_op       decoded opcode
//   mux_sel      1 = immediate operand, 0 = register operand
//   reg_write    destination write enable
//   rs, rt, rd   register addresses
//   imm          immediate value
//   hazard       combinational RAW stall indication
//   instr_count  saturating count of accepted instructions
//   stall_count  saturating count of stalled cycles
module decode_pipe_ctrl #(
    parameter  int OP_W      = 4,
    parameter  int REG_W     = 6,
    parameter  int IMM_W     = 15,
    parameter  int HAZ_DEPTH = 2,
    parameter  int CNT_W     = 16,
    localparam int INST_W    = 1 + OP_W + 2 * REG_W + IMM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [INST_W-1:0] in_inst,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   alu_op,
    output logic              mux_sel,
    output logic              reg_write,
    output logic [REG_W-1:0]  rs,
    output logic [REG_W-1:0]  rt,
    output logic [REG_W-1:0]  rd,
    output logic [IMM_W-1:0]  imm,
    output logic              hazard,
    output logic [CNT_W-1:0]  instr_count,
    output logic [CNT_W-1:0]  stall_count
);

    // Field extraction from the incoming word
    logic              in_ri;
    logic [OP_W-1:0]   in_op;
    logic [REG_W-1:0]  in_rd;
    logic [REG_W-1:0]  in_rs;
    logic [REG_W-1:0]  in_rt;
    logic [IMM_W-1:0]  in_imm;
    logic              in_wr;

    assign in_ri  = in_inst[INST_W-1];
    assign in_op  = in_inst[INST_W-2 -: OP_W];
    assign in_rd  = in_inst[IMM_W+2*REG_W-1 -: REG_W];
    assign in_rs  = in_inst[IMM_W+REG_W-1 -: REG_W];
    assign in_imm = in_inst[IMM_W-1:0];
    // I-type words have no rt; reporting 0 keeps it out of hazard matching
    assign in_rt  = in_ri ? '0 : in_imm[IMM_W-1 -: REG_W];
    // Writes to r0 and the all-zero NOP never create a dependency
    assign in_wr  = (in_inst != '0) && (in_rd != '0);

    // Scoreboard of recently retired destinations
    logic [HAZ_DEPTH-1:0] sb_valid;
    logic [REG_W-1:0]     sb_rd [HAZ_DEPTH];

    logic rs_hit;
    logic rt_hit;
    logic in_fire;
    logic out_fire;

    // Source match against the scoreboard and the instruction still held
    // in the output register (it has not yet entered the scoreboard).
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (sb_valid[i] && (sb_rd[i] == in_rs)) rs_hit = 1'b1;
            if (sb_valid[i] && (sb_rd[i] == in_rt)) rt_hit = 1'b1;
        end
        if (out_valid && reg_write && (rd == in_rs)) rs_hit = 1'b1;
        if (out_valid && reg_write && (rd == in_rt)) rt_hit = 1'b1;
    end

    assign hazard   = in_valid & (((in_rs != '0) & rs_hit) | ((in_rt != '0) & rt_hit));
    // rst_n gates in_ready so nothing can appear accepted while in reset
    assign in_ready = rst_n & (~out_valid | out_ready) & ~hazard & ~flush;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Output register: flush has priority, then a new load, then drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu_op    <= '0;
            mux_sel   <= 1'b0;
            reg_write <= 1'b0;
            rs        <= '0;
            rt        <= '0;
            rd        <= '0;
            imm       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            alu_op    <= in_op;
            mux_sel   <= in_ri;
            reg_write <= in_wr;
            rs        <= in_rs;
            rt        <= in_rt;
            rd        <= in_rd;
            imm       <= in_imm;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    // Scoreboard shifts every cycle; entry 0 captures a retiring writer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_valid <= '0;
            for (int i = 0; i < HAZ_DEPTH; i++) sb_rd[i] <= '0;
        end else if (flush) begin
            sb_valid <= '0;
            for (int i = 0; i < HAZ_DEPTH; i++) sb_rd[i] <= '0;
        end else begin
            for (int i = 1; i < HAZ_DEPTH; i++) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_rd[i]    <= sb_rd[i-1];
            end
            if (out_fire && reg_write) begin
                sb_valid[0] <= 1'b1;
                sb_rd[0]    <= rd;
            end else begin
                sb_valid[0] <= 1'b0;
                sb_rd[0]    <= '0;
            end
        end
    end

    // Saturating statistics; flush intentionally leaves them alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
            stall_count <= '0;
        end else begin
            if (in_fire && (instr_count != '1)) instr_count <= instr_count + 1'b1;
            if (hazard && (stall_count != '1)) stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_pipe_ctrl.sv
// tb_decode_pipe_ctrl
//
// Directed bench for decode_pipe_ctrl at default parameters, plus a second
// instance with CNT_W=4 sharing the same stimulus to observe saturation.
module tb_decode_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_op;
    logic        mux_sel;
    logic        reg_write;
    logic [5:0]  rs;
    logic [5:0]  rt;
    logic [5:0]  rd;
    logic [14:0] imm;
    logic        hazard;
    logic [15:0] instr_count;
    logic [15:0] stall_count;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [3:0]  s_alu_op;
    logic        s_mux_sel;
    logic        s_reg_write;
    logic [5:0]  s_rs;
    logic [5:0]  s_rt;
    logic [5:0]  s_rd;
    logic [14:0] s_imm;
    logic        s_hazard;
    logic [3:0]  s_instr_count;
    logic [3:0]  s_stall_count;

    int checks = 0;
    int errors = 0;

    decode_pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alu_op(alu_op), .mux_sel(mux_sel),
        .reg_write(reg_write), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .hazard(hazard), .instr_count(instr_count), .stall_count(stall_count)
    );

    decode_pipe_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst),
        .in_ready(s_in_ready), .flush(flush), .out_valid(s_out_valid),
        .out_ready(out_ready), .alu_op(s_alu_op), .mux_sel(s_mux_sel),
        .reg_write(s_reg_write), .rs(s_rs), .rt(s_rt), .rd(s_rd), .imm(s_imm),
        .hazard(s_hazard), .instr_count(s_instr_count), .stall_count(s_stall_count)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packs an instruction word: ri | op | rd | rs | imm
    function automatic logic [31:0] mk(input logic ri, input logic [3:0] op,
                                       input logic [5:0] d, input logic [5:0] s,
                                       input logic [14:0] im);
        return {ri, op, d, s, im};
    endfunction

    // Compares one observed value with its expected value and tallies it
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives the input side and lets combinational outputs settle
    task automatic applyStimulus(input logic v, input logic [31:0] inst,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    // Advances one clock, sampling just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);

        // Reset state
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_instr_count", instr_count, 0);
        repeat (2) tick();
        rst_n = 1'b1;

        // I-type decode
        applyStimulus(1'b1, mk(1'b1, 4'd1, 6'd2, 6'd1, 15'd20), 1'b1, 1'b0);
        checkOutput("itype_in_ready", in_ready, 1);
        checkOutput("itype_hazard", hazard, 0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("itype_out_valid", out_valid, 1);
        checkOutput("itype_alu_op", alu_op, 1);
        checkOutput("itype_mux_sel", mux_sel, 1);
        checkOutput("itype_rd", rd, 2);
        checkOutput("itype_rs", rs, 1);
        checkOutput("itype_rt", rt, 0);
        checkOutput("itype_imm", imm, 20);
        checkOutput("itype_reg_write", reg_write, 1);
        checkOutput("itype_instr_count", instr_count, 1);
        tick();
        checkOutput("drain_out_valid", out_valid, 0);
        repeat (3) tick();

        // NOP
        applyStimulus(1'b1, 32'd0, 1'b1, 1'b0);
        checkOutput("nop_in_ready", in_ready, 1);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("nop_out_valid", out_valid, 1);
        checkOutput("nop_reg_write", reg_write, 0);
        checkOutput("nop_instr_count", instr_count, 2);
        repeat (4) tick();

        // RAW stall: writer rd=5 then R-type reader with rt=5
        applyStimulus(1'b1, mk(1'b1, 4'd3, 6'd5, 6'd0, 15'd7), 1'b1, 1'b0);
        checkOutput("raw_a_in_ready", in_ready, 1);
        tick();
        applyStimulus(1'b1, mk(1'b0, 4'd2, 6'd6, 6'd0, 15'd2560), 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("raw_hazard_c%0d", c), hazard, 1);
            checkOutput($sformatf("raw_in_ready_c%0d", c), in_ready, 0);
            tick();
        end
        checkOutput("raw_release_hazard", hazard, 0);
        checkOutput("raw_release_in_ready", in_ready, 1);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("raw_stall_count", stall_count, 3);
        checkOutput("raw_b_rt", rt, 5);
        checkOutput("raw_b_rd", rd, 6);
        checkOutput("raw_b_mux_sel", mux_sel, 0);
        checkOutput("raw_instr_count", instr_count, 4);
        repeat (4) tick();

        // Backpressure
        applyStimulus(1'b1, mk(1'b1, 4'd4, 6'd7, 6'd0, 15'd33), 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, mk(1'b1, 4'd5, 6'd8, 6'd0, 15'd44), 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("bp_in_ready_c%0d", c), in_ready, 0);
            checkOutput($sformatf("bp_out_valid_c%0d", c), out_valid, 1);
            checkOutput($sformatf("bp_alu_op_c%0d", c), alu_op, 4);
            checkOutput($sformatf("bp_imm_c%0d", c), imm, 33);
            tick();
        end
        checkOutput("bp_hold_instr_count", instr_count, 5);
        applyStimulus(1'b1, mk(1'b1, 4'd5, 6'd8, 6'd0, 15'd44), 1'b1, 1'b0);
        checkOutput("bp_release_in_ready", in_ready, 1);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("bp_next_alu_op", alu_op, 5);
        checkOutput("bp_next_imm", imm, 44);
        checkOutput("bp_instr_count", instr_count, 6);
        repeat (4) tick();

        // Flush concurrent with in_valid and an output fire
        applyStimulus(1'b1, mk(1'b1, 4'd6, 6'd9, 6'd0, 15'd1), 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, mk(1'b1, 4'd7, 6'd10, 6'd0, 15'd2), 1'b1, 1'b1);
        checkOutput("flush_in_ready", in_ready, 0);
        tick();
        applyStimulus(1'b1, mk(1'b0, 4'd1, 6'd3, 6'd9, 15'd0), 1'b1, 1'b0);
        checkOutput("flush_out_valid", out_valid, 0);
        checkOutput("flush_instr_count", instr_count, 7);
        checkOutput("flush_hazard_cleared", hazard, 0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        repeat (4) tick();

        // Reset pulsed mid-stall
        applyStimulus(1'b1, mk(1'b1, 4'd2, 6'd11, 6'd0, 15'd3), 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, mk(1'b1, 4'd3, 6'd12, 6'd11, 15'd0), 1'b1, 1'b0);
        checkOutput("rstmid_hazard_before", hazard, 1);
        tick();
        checkOutput("rstmid_hazard_stall", hazard, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_out_valid", out_valid, 0);
        checkOutput("rstmid_alu_op", alu_op, 0);
        checkOutput("rstmid_rd", rd, 0);
        checkOutput("rstmid_imm", imm, 0);
        checkOutput("rstmid_hazard", hazard, 0);
        checkOutput("rstmid_in_ready", in_ready, 0);
        checkOutput("rstmid_instr_count", instr_count, 0);
        checkOutput("rstmid_stall_count", stall_count, 0);
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        tick();
        rst_n = 1'b1;

        // Saturation: 20 back-to-back independent instructions
        applyStimulus(1'b1, mk(1'b1, 4'd1, 6'd1, 6'd0, 15'd0), 1'b1, 1'b0);
        for (int c = 0; c < 20; c++) tick();
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
        checkOutput("sat_instr_count_w4", s_instr_count, 15);
        checkOutput("sat_instr_count_w16", instr_count, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
